id_gen: RTL and testbench

ID_GEN -- requirements
Module: id_gen

---
 rtl/id_gen_if.sv | 24 ++
 rtl/id_gen.sv | 119 +++++++++++
 tb/tb_id_gen.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/id_gen_if.sv
// Request/stream bundle for id_gen: the requester drives the request fields,
// and the generator returns one character per cycle plus its status strobes.
interface id_gen_if;
    logic       start;
    logic [3:0] alpha_len;
    logic [4:0] alpha_seed;
    logic [3:0] num_len;
    logic [3:0] num_seed;
    logic [7:0] char;
    logic       valid;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, alpha_len, alpha_seed, num_len, num_seed,
        input  char, valid, busy, done, err
    );

    modport slave (
        input  start, alpha_len, alpha_seed, num_len, num_seed,
        output char, valid, busy, done, err
    );
endinterface

// File: rtl/id_gen.sv
// Identifier stream generator: on request it emits alpha_len letters, then
// num_len digits, then one terminator character, one character per cycle.
module id_gen #(
    parameter logic [7:0] TERM_CHAR = 8'd32,
    parameter bit         UPPER     = 1'b0
) (
    input  logic     clk,
    input  logic     reset,
    id_gen_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ALPHA = 2'd1;
    localparam logic [1:0] NUM   = 2'd2;
    localparam logic [1:0] TERM  = 2'd3;

    localparam logic [7:0] BASE = UPPER ? 8'd65 : 8'd97;

    logic [1:0] state_q, state_d;
    logic [7:0] char_q, char_d;
    logic       err_q, err_d;
    logic [3:0] alen_q, alen_d;
    logic [3:0] nlen_q, nlen_d;
    logic [4:0] aidx_q, aidx_d;
    logic [3:0] didx_q, didx_d;
    logic [3:0] cnt_q, cnt_d;

    logic [4:0] aseed_norm;
    logic [3:0] nseed_norm;
    logic [4:0] aidx_nxt;
    logic [3:0] didx_nxt;

    // aidx_q/didx_q always hold the index of the character currently on char_q
    always_comb begin
        aseed_norm = (bus.alpha_seed > 5'd25) ? 5'd0 : bus.alpha_seed;
        nseed_norm = (bus.num_seed > 4'd9) ? 4'd0 : bus.num_seed;
        aidx_nxt   = (aidx_q == 5'd25) ? 5'd0 : aidx_q + 5'd1;
        didx_nxt   = (didx_q == 4'd9) ? 4'd0 : didx_q + 4'd1;

        state_d = state_q;
        char_d  = 8'd0;
        err_d   = 1'b0;
        alen_d  = alen_q;
        nlen_d  = nlen_q;
        aidx_d  = aidx_q;
        didx_d  = didx_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.alpha_len != 4'd0 && bus.num_len != 4'd0) begin
                        alen_d  = bus.alpha_len;
                        nlen_d  = bus.num_len;
                        aidx_d  = aseed_norm;
                        didx_d  = nseed_norm;
                        cnt_d   = 4'd1;
                        state_d = ALPHA;
                        char_d  = BASE + {3'd0, aseed_norm};
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ALPHA: begin
                if (cnt_q == alen_q) begin
                    state_d = NUM;
                    cnt_d   = 4'd1;
                    char_d  = 8'd48 + {4'd0, didx_q};
                end else begin
                    aidx_d = aidx_nxt;
                    cnt_d  = cnt_q + 4'd1;
                    char_d = BASE + {3'd0, aidx_nxt};
                end
            end
            NUM: begin
                if (cnt_q == nlen_q) begin
                    state_d = TERM;
                    char_d  = TERM_CHAR;
                end else begin
                    didx_d = didx_nxt;
                    cnt_d  = cnt_q + 4'd1;
                    char_d = 8'd48 + {4'd0, didx_nxt};
                end
            end
            default: begin
                // terminator cycle: start is ignored here, giving one idle cycle
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            char_q  <= 8'd0;
            err_q   <= 1'b0;
            alen_q  <= 4'd0;
            nlen_q  <= 4'd0;
            aidx_q  <= 5'd0;
            didx_q  <= 4'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            char_q  <= char_d;
            err_q   <= err_d;
            alen_q  <= alen_d;
            nlen_q  <= nlen_d;
            aidx_q  <= aidx_d;
            didx_q  <= didx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.char  = char_q;
    assign bus.valid = (state_q != IDLE);
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == TERM);
    assign bus.err   = err_q;
endmodule

// File: tb/tb_id_gen.sv
// Scoreboard bench for id_gen: stimulus queues hand-computed characters,
// a negedge monitor pops and compares them, including gaps and recognizer accept.
module tb_id_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    id_gen_if if0();
    id_gen_if if1();

    id_gen #(.TERM_CHAR(8'd32), .UPPER(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    id_gen #(.TERM_CHAR(8'd32), .UPPER(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    typedef struct {
        logic       is_err;
        logic [7:0] ch;
        logic       dn;
        int         gap;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int errors = 0;
    int checks = 0;
    int idle0 = 0, idle1 = 0;
    int rec0 = 0, rec1 = 0;

    task automatic push(input int p, input exp_t e);
        if (p == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // one expected stream: last character is the terminator and carries done
    task automatic push_str(input int p, input string s, input int first_gap);
        for (int i = 0; i < s.len(); i++) begin
            exp_t e;
            e.is_err = 1'b0;
            e.ch     = s[i];
            e.dn     = (i == s.len() - 1);
            e.gap    = (i == 0) ? first_gap : 0;
            push(p, e);
        end
    endtask

    task automatic push_err(input int p);
        exp_t e;
        e.is_err = 1'b1;
        e.ch     = 8'd0;
        e.dn     = 1'b0;
        e.gap    = -1;
        push(p, e);
    endtask

    task automatic mon(input int p, input logic [7:0] ch, input logic v, input logic b,
                       input logic d, input logic e);
        exp_t x;
        int   idle;
        int   rec;
        bit   empty;
        idle = (p == 0) ? idle0 : idle1;
        rec  = (p == 0) ? rec0 : rec1;
        checks++;
        if (!(b == v && (v || (ch == 8'd0 && !d)) && !(v && e))) begin
            errors++;
            $display("FAIL port%0d consistency: char=%h valid=%b busy=%b done=%b err=%b", p, ch, v, b, d, e);
        end
        if (v || e) begin
            empty = (p == 0) ? (q0.size() == 0) : (q1.size() == 0);
            checks++;
            if (empty) begin
                errors++;
                $display("FAIL port%0d unexpected output: char=%h valid=%b err=%b, expected none", p, ch, v, e);
            end else begin
                if (p == 0) x = q0.pop_front();
                else x = q1.pop_front();
                if (x.is_err) begin
                    if (!e || v) begin
                        errors++;
                        $display("FAIL port%0d err pulse: err=%b valid=%b, expected err=1 valid=0", p, e, v);
                    end
                end else begin
                    if (ch !== x.ch || d !== x.dn || e) begin
                        errors++;
                        $display("FAIL port%0d stream char: char=%h done=%b err=%b, expected char=%h done=%b err=0",
                                 p, ch, d, e, x.ch, x.dn);
                    end
                    if (x.gap >= 0) begin
                        checks++;
                        if (idle != x.gap) begin
                            errors++;
                            $display("FAIL port%0d gap: idle cycles=%0d, expected %0d", p, idle, x.gap);
                        end
                    end
                    if (ch == 8'd32) begin
                        checks++;
                        if (rec != 2) begin
                            errors++;
                            $display("FAIL port%0d recognizer accept on last digit: state=%0d, expected accept", p, rec);
                        end
                        rec = 0;
                    end else if ((ch >= 8'd97 && ch <= 8'd122) || (ch >= 8'd65 && ch <= 8'd90)) begin
                        rec = (rec == 0 || rec == 1) ? 1 : 3;
                    end else if (ch >= 8'd48 && ch <= 8'd57) begin
                        rec = (rec == 1 || rec == 2) ? 2 : 3;
                    end else begin
                        rec = 3;
                    end
                end
            end
            idle = 0;
        end else begin
            idle++;
        end
        if (p == 0) begin idle0 = idle; rec0 = rec; end
        else begin idle1 = idle; rec1 = rec; end
    endtask

    always @(negedge clk) begin
        mon(0, if0.char, if0.valid, if0.busy, if0.done, if0.err);
        mon(1, if1.char, if1.valid, if1.busy, if1.done, if1.err);
    end

    task automatic check_zero(input string name, input int p);
        logic [11:0] got;
        got = (p == 0) ? {if0.char, if0.valid, if0.busy, if0.done, if0.err}
                       : {if1.char, if1.valid, if1.busy, if1.done, if1.err};
        checks++;
        if (got !== 12'd0) begin
            errors++;
            $display("FAIL %s port%0d: {char,valid,busy,done,err}=%h, expected 000", name, p, got);
        end
    endtask

    task automatic wait_drain(input int p, input int budget);
        int  n;
        bit  pending;
        n = 0;
        pending = 1'b1;
        while (pending && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            pending = (p == 0) ? (q0.size() != 0 || if0.busy) : (q1.size() != 0 || if1.busy);
        end
        checks++;
        if (pending) begin
            errors++;
            $display("FAIL port%0d drain timeout: %0d items left after %0d cycles, expected 0", p,
                     (p == 0) ? q0.size() : q1.size(), budget);
        end
    endtask

    task automatic set0(input logic [3:0] al, input logic [4:0] as, input logic [3:0] nl, input logic [3:0] ns);
        if0.alpha_len = al; if0.alpha_seed = as; if0.num_len = nl; if0.num_seed = ns;
    endtask

    task automatic pulse0();
        if0.start = 1'b1;
        @(posedge clk); #1;
        if0.start = 1'b0;
    endtask

    initial begin
        int n;
        if0.start = 1'b0; set0(4'd0, 5'd0, 4'd0, 4'd0);
        if1.start = 1'b0; if1.alpha_len = 4'd0; if1.alpha_seed = 5'd0; if1.num_len = 4'd0; if1.num_seed = 4'd0;

        // reset before any clock edge, with start held high during reset
        #2;
        check_zero("reset state", 0);
        check_zero("reset state", 1);
        set0(4'd2, 5'd0, 4'd3, 4'd7);
        if0.start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("start during reset", 0);
        push_str(0, "ab789 ", -1);
        reset = 1'b0;
        @(posedge clk); #1;
        if0.start = 1'b0;
        set0(4'd15, 5'd3, 4'd9, 4'd5);
        @(posedge clk); #1;
        if0.start = 1'b1;
        @(posedge clk); #1;
        if0.start = 1'b0;
        wait_drain(0, 40);

        // uppercase instance, letter wrap Z->A, out-of-range digit seed
        if1.alpha_len = 4'd3; if1.alpha_seed = 5'd25; if1.num_len = 4'd1; if1.num_seed = 4'd12;
        push_str(1, "ZAB0 ", -1);
        if1.start = 1'b1;
        @(posedge clk); #1;
        if1.start = 1'b0;
        wait_drain(1, 40);

        // rejected requests
        set0(4'd0, 5'd0, 4'd4, 4'd0);
        push_err(0);
        pulse0();
        wait_drain(0, 10);
        set0(4'd5, 5'd0, 4'd0, 4'd0);
        push_err(0);
        pulse0();
        wait_drain(0, 10);

        // start held high: three back-to-back streams, one idle cycle apart
        set0(4'd1, 5'd0, 4'd1, 4'd0);
        push_str(0, "a0 ", -1);
        push_str(0, "a0 ", 1);
        push_str(0, "a0 ", 1);
        if0.start = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        if0.start = 1'b0;
        wait_drain(0, 40);

        // long stream with digit wrap 9->0 and letter wrap z->a
        set0(4'd4, 5'd24, 4'd12, 4'd9);
        push_str(0, "yzab901234567890 ", -1);
        pulse0();
        wait_drain(0, 60);

        // asynchronous reset during the second digit aborts the stream
        set0(4'd2, 5'd0, 4'd3, 4'd7);
        push_str(0, "ab789 ", -1);
        pulse0();
        n = 0;
        while (if0.char !== 8'h38 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (if0.char !== 8'h38) begin
            errors++;
            $display("FAIL second digit wait: char=%h, expected 38", if0.char);
        end
        #2;
        reset = 1'b1;
        #1;
        check_zero("async reset mid-stream", 0);
        q0.delete();
        rec0 = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        push_str(0, "ab789 ", -1);
        pulse0();
        wait_drain(0, 40);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
